// File: rtl/debounce_botones_pkg.sv
// Shared definitions for the push-button debouncer: default sizing,
// a short debounce length for simulation, and the per-button state type.
package debounce_botones_pkg;

    localparam int N_BOT_DEFAULT      = 3;
    localparam int DEB_CYCLES_DEFAULT = 1000000;  // 10 ms at 100 MHz
    localparam int DEB_CYCLES_SIM     = 4;

    typedef enum logic [1:0] {
        IDLE_LOW   = 2'd0,
        COUNT_UP   = 2'd1,
        IDLE_HIGH  = 2'd2,
        COUNT_DOWN = 2'd3
    } deb_state_e;

endpackage

// File: rtl/debounce_bit.sv
// Single-button conditioner: two-flop synchronizer, stability counter,
// debounced level and a one-cycle pulse on each debounced press.
//
// state      | meaning
// IDLE_LOW   | level 0, synchronized input agrees, count 0
// COUNT_UP   | level 0, synchronized input 1, counting stable cycles
// IDLE_HIGH  | level 1, synchronized input agrees, count 0
// COUNT_DOWN | level 1, synchronized input 0, counting stable cycles
module debounce_bit
    import debounce_botones_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic bot_in,
    output logic level,
    output logic pulse
);

    localparam int              CW      = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0]   CNT_ONE = CW'(1);

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    deb_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          pulse_q, pulse_d;

    // Next-state logic: synchronizer shift plus debounce FSM.
    // A mismatch always lasts at least one cycle before the flip, so the
    // entry into a COUNT state can load 1 directly (DEB_CYCLES >= 2).
    always_comb begin
        s1_d    = bot_in;
        s2_d    = s1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        pulse_d = 1'b0;
        case (state_q)
            IDLE_LOW: begin
                if (s2_q) begin
                    state_d = COUNT_UP;
                    cnt_d   = CNT_ONE;
                end
            end
            COUNT_UP: begin
                if (!s2_q) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            IDLE_HIGH: begin
                if (!s2_q) begin
                    state_d = COUNT_DOWN;
                    cnt_d   = CNT_ONE;
                end
            end
            COUNT_DOWN: begin
                if (s2_q) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE_LOW;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    assign level = level_q;
    assign pulse = pulse_q;

endmodule

// File: rtl/debounce_botones.sv
// Push-button front end: one debounce_bit per button, plus an optional
// priority filter that keeps the press pulses at most one-hot.
// Build option: define BOT_ONEHOT_EN to emit only the lowest-index pulse
// when several buttons are accepted on the same edge (others are dropped).
module debounce_botones
    import debounce_botones_pkg::*;
#(
    parameter int N_BOT      = N_BOT_DEFAULT,
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [N_BOT-1:0] BOT_IN,
    output logic [N_BOT-1:0] BOT_LEVEL,
    output logic [N_BOT-1:0] BOT_PULSE
);

    logic [N_BOT-1:0] pulse_raw;

    for (genvar i = 0; i < N_BOT; i++) begin : g_bot
        debounce_bit #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_bit (
            .clk    (CLK),
            .rst    (RESET),
            .bot_in (BOT_IN[i]),
            .level  (BOT_LEVEL[i]),
            .pulse  (pulse_raw[i])
        );
    end

`ifdef BOT_ONEHOT_EN
    // Keep only the lowest set bit, matching BOT[0] > BOT[1] > BOT[2] downstream.
    always_comb begin
        BOT_PULSE = pulse_raw & (~pulse_raw + N_BOT'(1));
    end
`else
    // Per-button pulses pass straight through.
    always_comb begin
        BOT_PULSE = pulse_raw;
    end
`endif

endmodule
